// File: rtl/fpu_rr_arbiter_if.sv
// rtl/fpu_rr_arbiter_if.sv - requester and FPU side signal bundle for fpu_rr_arbiter
interface fpu_rr_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int OP_W    = 2
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_din1;
   logic [NUM_REQ*DATA_W-1:0] req_din2;
   logic [NUM_REQ*OP_W-1:0]   req_op_sel;
   logic [NUM_REQ-1:0]        req_accept;
   logic [NUM_REQ-1:0]        resp_valid;
   logic [DATA_W-1:0]         resp_result;
   logic                      resp_error;
   logic                      busy;
   logic [DATA_W-1:0]         fpu_din1;
   logic [DATA_W-1:0]         fpu_din2;
   logic [OP_W-1:0]           fpu_op_sel;
   logic                      fpu_valid;
   logic [DATA_W-1:0]         fpu_result;
   logic                      fpu_ready;

   modport master (
      input  req_valid, req_din1, req_din2, req_op_sel, fpu_result, fpu_ready,
      output req_accept, resp_valid, resp_result, resp_error, busy,
             fpu_din1, fpu_din2, fpu_op_sel, fpu_valid
   );

   modport slave (
      output req_valid, req_din1, req_din2, req_op_sel, fpu_result, fpu_ready,
      input  req_accept, resp_valid, resp_result, resp_error, busy,
             fpu_din1, fpu_din2, fpu_op_sel, fpu_valid
   );
endinterface

// File: rtl/fpu_rr_arbiter.sv
// rtl/fpu_rr_arbiter.sv - round-robin sharing of one single-outstanding FPU among NUM_REQ requesters
// Optional watchdog: define FPU_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT cycles.
module fpu_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int OP_W    = 2,
   parameter int TIMEOUT = 64
) (
   input logic              clk,
   input logic              reset,
   fpu_rr_arbiter_if.master bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t           state;
   logic [IDX_W-1:0] last;
   logic [IDX_W-1:0] owner;
   logic [IDX_W-1:0] winner;
   logic             found;

   // Search starts just after the last served requester and wraps.
   always_comb begin
      int idx;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (!found && bus.req_valid[IDX_W'(idx)]) begin
            found  = 1'b1;
            winner = IDX_W'(idx);
         end
      end
   end

   assign bus.req_accept = (state == IDLE && found && !reset) ? (ONE << winner) : '0;

`ifdef FPU_TIMEOUT_EN
   logic [7:0] wdog;
`else
   assign bus.resp_error = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         owner           <= '0;
         last            <= IDX_W'(NUM_REQ - 1);
         bus.fpu_din1    <= '0;
         bus.fpu_din2    <= '0;
         bus.fpu_op_sel  <= '0;
         bus.fpu_valid   <= 1'b0;
         bus.resp_valid  <= '0;
         bus.resp_result <= '0;
         bus.busy        <= 1'b0;
`ifdef FPU_TIMEOUT_EN
         bus.resp_error  <= 1'b0;
         wdog            <= '0;
`endif
      end else begin
         bus.fpu_valid  <= 1'b0;
         bus.resp_valid <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  bus.fpu_din1   <= bus.req_din1[winner*DATA_W +: DATA_W];
                  bus.fpu_din2   <= bus.req_din2[winner*DATA_W +: DATA_W];
                  bus.fpu_op_sel <= bus.req_op_sel[winner*OP_W +: OP_W];
                  owner          <= winner;
                  bus.fpu_valid  <= 1'b1;
                  bus.busy       <= 1'b1;
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
`ifdef FPU_TIMEOUT_EN
               wdog  <= '0;
`endif
               state <= WAIT;
            end
            WAIT: begin
               if (bus.fpu_ready) begin
                  bus.resp_result <= bus.fpu_result;
                  bus.resp_valid  <= ONE << owner;
`ifdef FPU_TIMEOUT_EN
                  bus.resp_error  <= 1'b0;
`endif
                  state           <= RESP;
               end
`ifdef FPU_TIMEOUT_EN
               else if (wdog == 8'(TIMEOUT - 1)) begin
                  bus.resp_result <= '0;
                  bus.resp_valid  <= ONE << owner;
                  bus.resp_error  <= 1'b1;
                  state           <= RESP;
               end else begin
                  wdog <= wdog + 8'd1;
               end
`endif
            end
            RESP: begin
               last     <= owner;
               bus.busy <= 1'b0;
`ifdef FPU_TIMEOUT_EN
               bus.resp_error <= 1'b0;
`endif
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fpu_rr_arbiter.sv
// tb/tb_fpu_rr_arbiter.sv - randomized scoreboard bench for fpu_rr_arbiter with a behavioural arbitration model
module tb_fpu_rr_arbiter;
   localparam int N = 4;
`ifdef FPU_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fpu_rr_arbiter_if #(.NUM_REQ(N), .DATA_W(32), .OP_W(2)) bus ();
   fpu_rr_arbiter #(.NUM_REQ(N), .DATA_W(32), .OP_W(2), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   typedef struct {int id; logic [31:0] res; logic err;} resp_t;
   typedef struct {logic [N-1:0] acc; logic fv; logic busy; logic due;} cyc_t;

   resp_t       resp_q[$];
   cyc_t        cyc_q[$];
   int          tests = 0, errors = 0, cyc = 0;
   int          req_pct = 0, drop_pct = 0, spur_pct = 0, lat_fix = 1;
   logic [N-1:0] pend = '0, mask = '0;
   logic [31:0] d1[N], d2[N];
   logic [1:0]  opv[N];
   int          m_last = N - 1, m_gnt_c = 0, m_gnt_prev = -1;
   bit          m_out = 1'b0;
   bit          fpu_busy = 1'b0, hang = 1'b0, force_en = 1'b0;
   int          fpu_ready_c = -1;
   logic [31:0] fpu_res = '0, force_res = '0, last_result = '0;

   function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endfunction

   function automatic logic [31:0] fpu_f(logic [31:0] a, logic [31:0] b, logic [1:0] op);
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a ^ b;
         default: return a * b;
      endcase
   endfunction

   task automatic drive_reqs();
      bus.req_valid = pend;
      for (int i = 0; i < N; i++) begin
         bus.req_din1[i*32 +: 32] = d1[i];
         bus.req_din2[i*32 +: 32] = d2[i];
         bus.req_op_sel[i*2 +: 2] = opv[i];
      end
   endtask

   // One clock: FPU stimulus, requester churn, then the expected behaviour for this cycle.
   task automatic step();
      cyc_t e;
      int   resp_c, w;
      bit   idle;
      @(posedge clk);
      #1;
      cyc++;
      bus.fpu_ready = 1'b0;
      if (fpu_busy && fpu_ready_c == cyc) begin
         bus.fpu_ready  = 1'b1;
         bus.fpu_result = fpu_res;
         fpu_busy       = 1'b0;
      end else if (!fpu_busy && $urandom_range(0, 99) < spur_pct) begin
         bus.fpu_ready  = 1'b1;
         bus.fpu_result = $urandom;
      end
      if (m_gnt_prev >= 0) begin
         pend[m_gnt_prev] = 1'b0;
         m_gnt_prev = -1;
      end
      for (int i = 0; i < N; i++) begin
         if (pend[i] && $urandom_range(0, 99) < drop_pct) pend[i] = 1'b0;
         else if (!pend[i] && mask[i] && $urandom_range(0, 99) < req_pct) begin
            pend[i] = 1'b1;
            d1[i]   = $urandom;
            d2[i]   = $urandom;
            opv[i]  = 2'($urandom_range(0, 3));
         end
      end
      resp_c = 1 << 30;
      if (m_out) begin
         if (fpu_ready_c >= 0) resp_c = fpu_ready_c + 1;
         else if (hang && TO_EN) resp_c = m_gnt_c + 10;
      end
      idle   = !m_out || cyc > resp_c;
      e      = '{acc: '0, fv: 1'b0, busy: 1'b0, due: 1'b0};
      e.busy = !idle;
      e.fv   = m_out && cyc == m_gnt_c + 1;
      e.due  = m_out && cyc == resp_c;
      if (idle) m_out = 1'b0;
      if (idle && pend != '0) begin
         w = -1;
         for (int k = 1; k <= N; k++)
            if (w < 0 && pend[(m_last + k) % N]) w = (m_last + k) % N;
         e.acc[w]    = 1'b1;
         m_out       = 1'b1;
         m_gnt_c     = cyc;
         m_last      = w;
         m_gnt_prev  = w;
         fpu_ready_c = -1;
         if (hang) resp_q.push_back('{id: w, res: 32'h0, err: 1'b1});
         else resp_q.push_back('{id: w, res: force_en ? force_res : fpu_f(d1[w], d2[w], opv[w]), err: 1'b0});
      end
      cyc_q.push_back(e);
      drive_reqs();
   endtask

   task automatic do_reset();
      req_pct = 0;
      reset = 1'b1;
      #1;
      chk("rst_accept", 32'(bus.req_accept), 0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 0);
      chk("rst_resp_result", bus.resp_result, 0);
      chk("rst_resp_error", 32'(bus.resp_error), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_fpu_din1", bus.fpu_din1, 0);
      chk("rst_fpu_din2", bus.fpu_din2, 0);
      chk("rst_fpu_op_sel", 32'(bus.fpu_op_sel), 0);
      chk("rst_fpu_valid", 32'(bus.fpu_valid), 0);
      if (resp_q.size() > 0) resp_q.delete(resp_q.size() - 1);
      m_out = 1'b0;
      m_last = N - 1;
      m_gnt_prev = -1;
      last_result = '0;
      pend = '0;
      drive_reqs();
      if (hang) fpu_busy = 1'b0;
      if (cyc > 0) begin
         cyc_q.delete();
         cyc_q.push_back('{acc: '0, fv: 1'b0, busy: 1'b0, due: 1'b0});
      end
      step();
      reset = 1'b0;
   endtask

   task automatic drain();
      req_pct = 0;
      for (int k = 0; k < 400; k++) begin
         if (pend == '0 && resp_q.size() == 0 && !fpu_busy && !m_out) break;
         step();
      end
      repeat (2) step();
   endtask

   // FPU model: accepts the issued operands and schedules its ready pulse.
   always @(negedge clk) begin
      if (bus.fpu_valid === 1'b1) begin
         fpu_busy = 1'b1;
         if (hang) fpu_ready_c = -1;
         else fpu_ready_c = cyc + ((lat_fix > 0) ? lat_fix : int'($urandom_range(1, 5)));
         fpu_res = force_en ? force_res : fpu_f(bus.fpu_din1, bus.fpu_din2, bus.fpu_op_sel);
      end
   end

   always @(negedge clk) begin
      cyc_t  e;
      resp_t r;
      if (cyc_q.size() > 0) begin
         e = cyc_q.pop_front();
         chk("req_accept", 32'(bus.req_accept), 32'(e.acc));
         chk("fpu_valid", 32'(bus.fpu_valid), 32'(e.fv));
         chk("busy", 32'(bus.busy), 32'(e.busy));
         chk("resp_strobe", 32'(|bus.resp_valid), 32'(e.due));
         if (bus.resp_valid != '0) begin
            if (resp_q.size() == 0) chk("unexpected_resp", 32'(bus.resp_valid), 0);
            else begin
               r = resp_q.pop_front();
               chk("resp_owner", 32'(bus.resp_valid), 32'd1 << r.id);
               chk("resp_result", bus.resp_result, r.res);
               chk("resp_error", 32'(bus.resp_error), 32'(r.err));
               last_result = r.res;
            end
         end else begin
            chk("resp_hold", bus.resp_result, last_result);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish, expected finish by 400000");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         d1[i] = '0; d2[i] = '0; opv[i] = '0;
      end
      bus.fpu_ready  = 1'b0;
      bus.fpu_result = '0;
      drive_reqs();
      do_reset();

      force_en = 1'b1; force_res = 32'h4040_0000; lat_fix = 3;
      d1[0] = 32'h3F80_0000; d2[0] = 32'h4000_0000; opv[0] = 2'd0; pend[0] = 1'b1;
      repeat (10) step();
      force_en = 1'b0;

      mask = 4'b1111; req_pct = 100; lat_fix = 1;
      repeat (24) step();
      drain();

      mask = 4'b0100; req_pct = 100;
      repeat (10) step();
      mask = 4'b0101; req_pct = 100;
      repeat (24) step();
      drain();

      mask = 4'b1111; req_pct = 30; drop_pct = 5; spur_pct = 15; lat_fix = 0;
      repeat (800) step();
      drain();
      drop_pct = 0;

      spur_pct = 50;
      repeat (30) step();
      spur_pct = 0;

      lat_fix = 5; mask = '0;
      d1[1] = $urandom; d2[1] = $urandom; opv[1] = 2'd3; pend[1] = 1'b1;
      repeat (5) step();
      do_reset();
      repeat (6) step();
      mask = 4'b1111; req_pct = 100; lat_fix = 1;
      repeat (12) step();
      drain();

      hang = 1'b1; mask = '0;
      d1[2] = $urandom; d2[2] = $urandom; opv[2] = 2'd1; pend[2] = 1'b1;
      repeat (30) step();
      do_reset();
      hang = 1'b0;
      drain();

      chk("queue_empty", 32'(resp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule

// File: doc/fpu_rr_arbiter.md
Name: fpu_rr_arbiter

Overview:
- Shares one single-outstanding FPU (`fpu_top`: din1/din2/op_sel/valid in, result/ready out) between NUM_REQ requesters.
- Arbitration is round-robin.
- The block latches the winner's operands, issues a one-cycle valid pulse to the FPU, and waits for ready.
- It returns the result to the owning requester only; it sits between the issue-side clients and `fpu_top`.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, operand/result width
- OP_W, 2, op_sel width
- TIMEOUT, 64, watchdog limit in cycles (used only with FPU_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request; held until accepted
- req_din1  in  NUM_REQ*DATA_W  packed operand 1, slice i = requester i
- req_din2  in  NUM_REQ*DATA_W  packed operand 2
- req_op_sel  in  NUM_REQ*OP_W  packed op select
- req_accept  out  NUM_REQ  one-hot, one-cycle accept of the granted request
- resp_valid  out  NUM_REQ  one-hot, one-cycle result strobe
- resp_result  out  DATA_W  result, valid when any resp_valid bit is set
- resp_error  out  1  timeout flag, qualified by resp_valid (FPU_TIMEOUT_EN only, else 0)
- busy  out  1  high whenever state != IDLE
- fpu_din1  out  DATA_W  to FPU din1
- fpu_din2  out  DATA_W  to FPU din2
- fpu_op_sel  out  OP_W  to FPU op_sel
- fpu_valid  out  1  to FPU valid, one-cycle pulse
- fpu_result  in  DATA_W  from FPU result
- fpu_ready  in  1  from FPU ready, one-cycle pulse with valid result

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP; 2-bit state register.
- Reset (async, any state) forces:
  - state=IDLE, owner=0, rr pointer last=NUM_REQ-1 (so requester 0 has first priority);
  - operand/result regs = 0;
  - all outputs 0: req_accept, resp_valid, resp_result, resp_error, busy, fpu_din1/din2/op_sel, fpu_valid.
- An in-flight operation is abandoned on reset. A late fpu_ready after reset is ignored because state is IDLE.
- IDLE:
  - If any req_valid, winner = first set bit searching last+1, last+2, ... wrapping modulo NUM_REQ.
  - req_accept[winner]=1 combinationally in the same cycle.
  - On that edge: latch winner's din1/din2/op_sel into fpu_din1/din2/op_sel regs, owner=winner, go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE: fpu_valid=1 for exactly this cycle; next state WAIT. Operand regs are held stable until RESP exits.
- WAIT:
  - fpu_ready is sampled here only.
  - On fpu_ready=1: capture fpu_result into the result reg, go to RESP.
  - fpu_ready in any other state is ignored.
- RESP:
  - resp_valid[owner]=1 for one cycle, resp_result=captured value.
  - last=owner; next state IDLE.
  - A new grant is possible on the following cycle.
- Latency:
  - Accept at cycle T, fpu_valid at T+1.
  - If ready arrives at T+1+L (L>=1), resp_valid is at T+2+L.
  - Minimum accept-to-accept spacing is 4 cycles.
- Fairness:
  - A requester that keeps req_valid asserted receives a grant within NUM_REQ grants.
  - A lone requester is granted back-to-back.
- A request deasserted before accept is dropped without side effects.
- A req_valid for the current owner during ISSUE/WAIT/RESP is not accepted until IDLE.
- resp_result holds its last value between strobes.

Optional Feature:
- Macro: FPU_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 without fpu_ready, go to RESP with resp_result=0 and resp_error=1.
  - Otherwise resp_error=0 on every response.
- Not defined: no counter; WAIT waits indefinitely; resp_error is tied to 0.

Test Plan:
- Reset, then req_valid=4'b0001, din1=0x3F800000, din2=0x40000000, op=00; FPU model returns ready with 0x40400000 after 3 cycles -> req_accept=0001 at T, fpu_valid at T+1 only, resp_valid=0001 with resp_result=0x40400000 at T+5, busy high T+1..T+5.
- All four req_valid held high continuously -> grant order 0,1,2,3,0 with accepts exactly 4 cycles apart for a 1-cycle FPU; each resp_valid one-hot matches the grant.
- req_valid=0101 after requester 2 was last served -> requester 0 granted first, then 2; never 2 twice in a row.
- Reset asserted during WAIT, fpu_ready pulsed 2 cycles later -> all outputs 0 immediately (async), no resp_valid, next request granted normally starting with requester 0.
- Spurious fpu_ready in IDLE and ISSUE -> ignored; result reg unchanged, no resp_valid.
- With FPU_TIMEOUT_EN and TIMEOUT=8, FPU never readies -> resp_valid[owner]=1, resp_error=1, resp_result=0 after 8 WAIT cycles; without the macro, busy stays high.
